seg_scan_ctrl: RTL

//   Parametrised multiplexed 7-segment scan controller for the digital clock display.
//   - Time-multiplexes DIGITS packed BCD digits onto one shared segment bus, with

---
 rtl/seg_scan_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed 7-segment scan controller for the digital clock display.
// A set of packed BCD digits is time-multiplexed onto one shared segment bus.
// Each digit gets a slot of DIV clock cycles. The first BLANK cycles of every
// slot keep all anodes off, so the previous digit does not ghost onto the next.
// The Data/Dp/Mask inputs are copied into shadow registers once per frame, so a
// frame always shows one consistent value.
//
// Ports
//   Clk    in   1         system clock, rising edge
//   Rst_n  in   1         asynchronous reset, active low
//   EN     in   1         display enable, active high
//   Data   in   4*DIGITS  packed BCD, digit i = Data[4i+3:4i], digit 0 rightmost
//   Dp     in   DIGITS    decimal point request per digit, active high
//   Mask   in   DIGITS    digit enable per digit, active high
//   AN     out  DIGITS    digit anode select, active low
//   NUM    out  4         BCD value of the digit currently selected
//   SEG    out  8         segment drive, active low, {dp,g,f,e,d,c,b,a}
//   Frame  out  1         one-cycle pulse on the first output cycle of digit 0
//
// Build option
//   SEG_SCAN_LZB_EN : when defined, leading zeros are blanked. Digit i (i >= 1)
//                     stays dark while it and every higher digit are zero.
//                     When undefined, zero digits display as 0.

module seg_scan_ctrl #(
   parameter int DIGITS = 6,
   parameter int DIV    = 1000,
   parameter int BLANK  = 4
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                EN,
   input  logic [4*DIGITS-1:0] Data,
   input  logic [DIGITS-1:0]   Dp,
   input  logic [DIGITS-1:0]   Mask,
   output logic [DIGITS-1:0]   AN,
   output logic [3:0]          NUM,
   output logic [7:0]          SEG,
   output logic                Frame
);

   localparam int CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CntW-1:0] cntLast = CntW'(DIV - 1);
   localparam logic [IdxW-1:0] idxLast = IdxW'(DIGITS - 1);

   logic [CntW-1:0]     cnt;
   logic [IdxW-1:0]     idx;
   logic [4*DIGITS-1:0] shadowData;
   logic [DIGITS-1:0]   shadowDp;
   logic [DIGITS-1:0]   shadowMask;
   logic                framePending;

   logic                slotEnd;
   logic                frameWrap;
   logic                blankWin;
   logic [3:0]          curDigit;
   logic                curDp;
   logic                curMask;
   logic                curLzb;
   logic [DIGITS-1:0]   lzbMask;
   logic [DIGITS-1:0]   anOneHot;
   logic                darkSlot;

   // Active-low segment patterns {g,f,e,d,c,b,a}. The codes A..E have no glyph
   // and show nothing. F is used by the clock as a minus sign.
   function automatic logic [6:0] decodeDigit(input logic [3:0] v);
      logic [6:0] pat;
      case (v)
         4'd0:    pat = 7'h40;
         4'd1:    pat = 7'h79;
         4'd2:    pat = 7'h24;
         4'd3:    pat = 7'h30;
         4'd4:    pat = 7'h19;
         4'd5:    pat = 7'h12;
         4'd6:    pat = 7'h02;
         4'd7:    pat = 7'h78;
         4'd8:    pat = 7'h00;
         4'd9:    pat = 7'h10;
         4'hF:    pat = 7'h3F;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   // A slot ends on the last count value. A frame ends when the last digit's
   // slot ends. That frame-end cycle is the only moment the shadow registers
   // reload while scanning.
   always_comb begin
      slotEnd   = (cnt == cntLast);
      frameWrap = slotEnd && (idx == idxLast);
      blankWin  = (int'(cnt) < BLANK);
   end

   // Leading-zero map. Bit i is set when shadow digit i and all digits above it
   // are zero. The loop walks down from the top digit and keeps a running AND.
   // Digit 0 is never included, so a time of all zeros still shows "0".
`ifdef SEG_SCAN_LZB_EN
   logic allZero;
   always_comb begin
      allZero = 1'b1;
      lzbMask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         allZero    = allZero && (shadowData[4*i +: 4] == 4'd0);
         lzbMask[i] = allZero;
      end
   end
`else
   always_comb begin
      lzbMask = '0;
   end
`endif

   // Select everything about the digit under the scan pointer from the shadow
   // copy. A compare-per-digit loop is used instead of a computed part-select,
   // so the logic stays legal for any DIGITS value.
   always_comb begin
      curDigit = 4'd0;
      curDp    = 1'b0;
      curMask  = 1'b0;
      curLzb   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IdxW'(i)) begin
            curDigit = shadowData[4*i +: 4];
            curDp    = shadowDp[i];
            curMask  = shadowMask[i];
            curLzb   = lzbMask[i];
         end
      end
      anOneHot = DIGITS'(1) << idx;
      darkSlot = blankWin || !curMask || curLzb;
   end

   // Scan position: cnt walks through one slot, and idx steps to the next
   // digit at the end of each slot. While the display is disabled both are
   // parked at zero. Re-enabling therefore always begins with a fresh digit 0
   // slot, including its full blank window.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!EN) begin
         cnt <= '0;
         idx <= '0;
      end else if (slotEnd) begin
         cnt <= '0;
         idx <= (idx == idxLast) ? '0 : idx + IdxW'(1);
      end else begin
         cnt <= cnt + CntW'(1);
      end
   end

   // Shadow copy of the inputs. It follows the inputs every cycle while the
   // display is off. While scanning it only reloads at the frame wrap, so a
   // change part-way through a frame waits for the next frame.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         shadowData <= '0;
         shadowDp   <= '0;
         shadowMask <= '0;
      end else if (!EN || frameWrap) begin
         shadowData <= Data;
         shadowDp   <= Dp;
         shadowMask <= Mask;
      end
   end

   // Registered outputs, one cycle behind the scan position that produces them.
   // framePending remembers that a frame wrap just happened. Frame then lines
   // up with the first output cycle of digit 0 in the new frame. The first
   // slot after enable or reset did not come from a wrap, so it gets no pulse.
   // NUM follows the selected shadow digit even while the anodes are dark.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         AN           <= '1;
         SEG          <= 8'hFF;
         NUM          <= 4'd0;
         Frame        <= 1'b0;
         framePending <= 1'b0;
      end else begin
         NUM <= curDigit;
         if (!EN) begin
            AN           <= '1;
            SEG          <= 8'hFF;
            Frame        <= 1'b0;
            framePending <= 1'b0;
         end else begin
            Frame        <= framePending;
            framePending <= frameWrap;
            if (darkSlot) begin
               AN  <= '1;
               SEG <= 8'hFF;
            end else begin
               AN  <= ~anOneHot;
               SEG <= {~curDp, decodeDigit(curDigit)};
            end
         end
      end
   end

endmodule
